sig_slicer: RTL and testbench

- Converts the downsampled ADC stream into the 1-bit square wave consumed by the period/frequency classifier (its `sigin`).
- Uses an adaptive mid-level threshold recomputed every window from the running min/max, plus a hysteresis band and a consecutive-sample deglitch filter.
- Sits directly between the downsampler output and the period-measurement stage.

---
 rtl/sig_slicer_pkg.sv | 12 +
 rtl/sig_slicer_if.sv | 24 ++
 rtl/sig_slicer_minmax_window.sv | 43 ++++
 rtl/sig_slicer.sv | 76 +++++++
 tb/tb_sig_slicer.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/sig_slicer_pkg.sv
// sig_slicer_pkg: shared widths and timing defaults for the slicer and the period stage
package sig_slicer_pkg;
    localparam int DW_DEF         = 12;
    localparam int WIN_LOG2_DEF   = 16;
    localparam int HYST_SHIFT_DEF = 3;
    localparam int DEGLITCH_DEF   = 4;
    localparam int MIN_AMP_DEF    = 32;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/sig_slicer_if.sv
// sig_slicer_if: sample input and sliced-output bundle between downsampler, slicer and period stage
interface sig_slicer_if
    import sig_slicer_pkg::*;
#(
    parameter int DW = DW_DEF
);
    logic          din_valid;
    logic [DW-1:0] din;
    logic          sig_out;
    logic          rise_pulse;
    logic          amp_ok;
    logic [DW-1:0] th_hi;
    logic [DW-1:0] th_lo;

    modport master (
        output din_valid, din,
        input  sig_out, rise_pulse, amp_ok, th_hi, th_lo
    );

    modport slave (
        input  din_valid, din,
        output sig_out, rise_pulse, amp_ok, th_hi, th_lo
    );
endinterface

// File: rtl/sig_slicer_minmax_window.sv
// sig_slicer_minmax_window: running min/max over 2^WIN_LOG2 valid samples, amp/mid on the closing sample
module sig_slicer_minmax_window
    import sig_slicer_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din_valid,
    input  logic [DW-1:0] din,
    output logic          win_done,
    output logic [DW-1:0] amp,
    output logic [DW-1:0] mid
);
    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [DW-1:0]       max_q, max_d, min_q, min_d, cur_max, cur_min;

    // the closing sample is folded into amp/mid combinationally so the window includes it
    always_comb begin
        cur_max  = (din > max_q) ? din : max_q;
        cur_min  = (din < min_q) ? din : min_q;
        win_done = din_valid && (cnt_q == '1);
        amp      = cur_max - cur_min;
        mid      = DW'(({1'b0, cur_max} + {1'b0, cur_min}) >> 1);
        cnt_d    = din_valid ? cnt_q + 1'b1 : cnt_q;
        max_d    = win_done ? '0 : din_valid ? cur_max : max_q;
        min_d    = win_done ? '1 : din_valid ? cur_min : min_q;
    end

    // window state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            max_q <= '0;
            min_q <= '1;
        end else begin
            cnt_q <= cnt_d;
            max_q <= max_d;
            min_q <= min_d;
        end
    end
endmodule

// File: rtl/sig_slicer.sv
// sig_slicer: adaptive-threshold hysteresis slicer with deglitch, ADC samples to 1-bit square wave
module sig_slicer
    import sig_slicer_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int WIN_LOG2   = WIN_LOG2_DEF,
    parameter int HYST_SHIFT = HYST_SHIFT_DEF,
    parameter int DEGLITCH   = DEGLITCH_DEF,
    parameter int MIN_AMP    = MIN_AMP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    sig_slicer_if.slave bus
);
    localparam int CW = cnt_w(DEGLITCH);

    logic          win_done;
    logic [DW-1:0] amp, mid, h;
    logic          cand, toggle;
    logic          sig_q, sig_d, rise_q, rise_d, amp_ok_q, amp_ok_d;
    logic [DW-1:0] th_hi_q, th_hi_d, th_lo_q, th_lo_d;
    logic [CW-1:0] cnt_q, cnt_d;

    sig_slicer_minmax_window #(
        .DW       (DW),
        .WIN_LOG2 (WIN_LOG2)
    ) u_win (
        .clk       (clk),
        .rst       (rst),
        .din_valid (bus.din_valid),
        .din       (bus.din),
        .win_done  (win_done),
        .amp       (amp),
        .mid       (mid)
    );

    // the sample is judged against the old thresholds; a failing new amp_ok overrides any toggle
    always_comb begin
        h        = amp >> HYST_SHIFT;
        cand     = (bus.din >= th_hi_q) ? 1'b1 : (bus.din <= th_lo_q) ? 1'b0 : sig_q;
        amp_ok_d = win_done ? (amp >= DW'(MIN_AMP)) : amp_ok_q;
        th_hi_d  = win_done ? mid + h : th_hi_q;
        th_lo_d  = win_done ? mid - h : th_lo_q;
        toggle   = amp_ok_q && (cand != sig_q) && (cnt_q == CW'(DEGLITCH - 1));
        cnt_d    = !bus.din_valid ? cnt_q :
                   (!amp_ok_q || !amp_ok_d || cand == sig_q || toggle) ? '0 : cnt_q + 1'b1;
        sig_d    = !bus.din_valid ? sig_q :
                   (!amp_ok_q || !amp_ok_d) ? 1'b0 : toggle ? !sig_q : sig_q;
        rise_d   = sig_d && !sig_q;
    end

    // output and deglitch state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q    <= 1'b0;
            rise_q   <= 1'b0;
            amp_ok_q <= 1'b0;
            th_hi_q  <= '0;
            th_lo_q  <= '0;
            cnt_q    <= '0;
        end else begin
            sig_q    <= sig_d;
            rise_q   <= rise_d;
            amp_ok_q <= amp_ok_d;
            th_hi_q  <= th_hi_d;
            th_lo_q  <= th_lo_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.sig_out    = sig_q;
    assign bus.rise_pulse = rise_q;
    assign bus.amp_ok     = amp_ok_q;
    assign bus.th_hi      = th_hi_q;
    assign bus.th_lo      = th_lo_q;
endmodule

// File: tb/tb_sig_slicer.sv
// tb_sig_slicer: directed-vector bench for sig_slicer with hand-computed expectations
module tb_sig_slicer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sig_slicer_if #(.DW(12)) bus ();

    sig_slicer #(
        .DW         (12),
        .WIN_LOG2   (4),
        .HYST_SHIFT (3),
        .DEGLITCH   (4),
        .MIN_AMP    (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int s, input int r, input int a, input int hi, input int lo);
        chk({tag, "_sig"}, 32'(bus.sig_out), s);
        chk({tag, "_rise"}, 32'(bus.rise_pulse), r);
        chk({tag, "_amp_ok"}, 32'(bus.amp_ok), a);
        chk({tag, "_th_hi"}, 32'(bus.th_hi), hi);
        chk({tag, "_th_lo"}, 32'(bus.th_lo), lo);
    endtask

    task automatic step(input logic v, input int d);
        bus.din_valid = v;
        bus.din       = 12'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int d, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            step(1'b1, d);
            for (int g = 0; g < gap; g++) step(1'b0, d);
        end
    endtask

    task automatic rst_seq();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'(i % 2 == 0), 3000);
            chk_all("rst", 0, 0, 0, 0, 0);
        end
        rst = 1'b0;
    endtask

    task automatic establish(input int gap);
        feed(1000, 8, gap);
        feed(3000, 7, gap);
        chk_all("est_pre", 0, 0, 0, 0, 0);
        feed(3000, 1, gap);
        chk_all("est_done", 0, 0, 1, 2250, 1750);
    endtask

    initial begin
        bus.din_valid = 1'b0;
        bus.din       = '0;

        rst_seq();
        establish(0);
        feed(1000, 8, 0);
        chk("s2_low_hold", 32'(bus.sig_out), 0);
        feed(3000, 3, 0);
        chk("s2_pre_rise", 32'(bus.sig_out), 0);
        feed(3000, 1, 0);
        chk_all("s2_rise", 1, 1, 1, 2250, 1750);
        feed(3000, 1, 0);
        chk_all("s2_after_rise", 1, 0, 1, 2250, 1750);
        feed(3000, 3, 0);
        chk_all("s2_win2_end", 1, 0, 1, 2250, 1750);
        feed(1000, 3, 0);
        chk("s2_pre_fall", 32'(bus.sig_out), 1);
        feed(1000, 1, 0);
        chk_all("s2_fall", 0, 0, 1, 2250, 1750);

        rst_seq();
        establish(0);
        feed(1000, 2, 0);
        feed(3000, 3, 0);
        chk("s3_burst3", 32'(bus.sig_out), 0);
        feed(1000, 1, 0);
        chk("s3_back_low", 32'(bus.sig_out), 0);
        feed(3000, 3, 0);
        chk("s3_burst4_pre", 32'(bus.sig_out), 0);
        feed(3000, 1, 0);
        chk_all("s3_burst4_rise", 1, 1, 1, 2250, 1750);
        step(1'b0, 1000);
        chk_all("s3_idle_hold", 1, 0, 1, 2250, 1750);
        feed(2000, 5, 0);
        chk("s3_inband_hold", 32'(bus.sig_out), 1);
        feed(3000, 1, 0);
        chk_all("s3_win_end", 1, 0, 1, 2250, 1750);

        rst_seq();
        for (int i = 0; i < 8; i++) begin
            feed(2010, 1, 0);
            feed(1990, 1, 0);
        end
        chk_all("s4_small_win", 0, 0, 0, 2002, 1998);
        feed(2010, 8, 0);
        chk("s4_forced_low", 32'(bus.sig_out), 0);
        feed(1990, 8, 0);
        chk_all("s4_small_win2", 0, 0, 0, 2002, 1998);
        feed(1000, 8, 0);
        feed(3000, 8, 0);
        chk_all("s4_amp_ok_rise", 0, 0, 1, 2250, 1750);
        feed(3000, 3, 0);
        chk("s4_pre_rise", 32'(bus.sig_out), 0);
        feed(3000, 1, 0);
        chk_all("s4_rise", 1, 1, 1, 2250, 1750);
        feed(3000, 11, 0);
        chk_all("s4_flat_pre_end", 1, 0, 1, 2250, 1750);
        feed(3000, 1, 0);
        chk_all("s4_flat_end_force", 0, 0, 0, 3000, 3000);

        rst_seq();
        establish(9);
        feed(1000, 8, 9);
        feed(3000, 3, 9);
        chk("s5_pre_rise", 32'(bus.sig_out), 0);
        feed(3000, 1, 0);
        chk_all("s5_rise", 1, 1, 1, 2250, 1750);
        step(1'b0, 3000);
        chk_all("s5_rise_width", 1, 0, 1, 2250, 1750);
        step(1'b0, 3000);
        chk("s5_hold", 32'(bus.sig_out), 1);

        rst_seq();
        feed(500, 8, 0);
        rst = 1'b1;
        step(1'b1, 3000);
        rst = 1'b0;
        chk_all("s6_mid_rst", 0, 0, 0, 0, 0);
        feed(1000, 8, 0);
        chk("s6_no_early_latch", 32'(bus.th_hi), 0);
        feed(3000, 7, 0);
        chk_all("s6_pre_latch", 0, 0, 0, 0, 0);
        feed(3000, 1, 0);
        chk_all("s6_latch", 0, 0, 1, 2250, 1750);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
